// File: rtl/seg_pkg.sv
// Shared constants for the BCD seven-segment scanner: segment patterns,
// display geometry and the bit offsets of the fields inside the signed BCD word.
package seg_pkg;

  localparam int NUM_POS    = 6;
  localparam int NUM_DIGITS = 5;
  localparam int DIGIT_W    = 4;
  localparam int SEG_W      = 7;
  localparam int BCD_W      = 21;

  // bcd_in field offsets
  localparam int UNITS_LSB         = 0;
  localparam int TENS_LSB          = 4;
  localparam int HUNDREDS_LSB      = 8;
  localparam int THOUSANDS_LSB     = 12;
  localparam int TEN_THOUSANDS_LSB = 16;
  localparam int SIGN_BIT          = 20;

  // segment patterns {g,f,e,d,c,b,a}, active-high
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to seven-segment decoder; non-decimal codes
// (A-F) produce a blank pattern.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [SEG_W-1:0]   o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Six-position multiplexed display scanner for a signed five-digit BCD value.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module bcd_seg_scanner
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BCD_W-1:0]   bcd_in,
  input  logic               v,
  output logic [NUM_POS-1:0] an,
  output logic [SEG_W-1:0]   seg,
  output logic               frame
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_idx;
  logic [BCD_W-1:0]   r_snap;
  logic               r_snap_v;
  logic [NUM_POS-1:0] r_an;
  logic [SEG_W-1:0]   r_seg;
  logic               r_frame;

  logic               w_tick;
  logic               w_wrap;
  logic [2:0]         w_idx_next;
  logic [BCD_W-1:0]   w_src_bcd;
  logic               w_src_v;
  logic [DIGIT_W-1:0] w_digit;
  logic [SEG_W-1:0]   w_dec_seg;
  logic               w_blank;
  logic [SEG_W-1:0]   w_seg_next;

  assign w_tick     = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign w_wrap     = w_tick && (r_idx == 3'(NUM_POS - 1));
  assign w_idx_next = (r_idx == 3'(NUM_POS - 1)) ? 3'd0 : r_idx + 3'd1;

  // The registered pattern must already reflect a snapshot loaded on this edge.
  assign w_src_bcd = w_wrap ? bcd_in : r_snap;
  assign w_src_v   = w_wrap ? v      : r_snap_v;

  always_comb begin
    w_digit = '0;
    case (w_idx_next)
      3'd0:    w_digit = w_src_bcd[UNITS_LSB         +: DIGIT_W];
      3'd1:    w_digit = w_src_bcd[TENS_LSB          +: DIGIT_W];
      3'd2:    w_digit = w_src_bcd[HUNDREDS_LSB      +: DIGIT_W];
      3'd3:    w_digit = w_src_bcd[THOUSANDS_LSB     +: DIGIT_W];
      3'd4:    w_digit = w_src_bcd[TEN_THOUSANDS_LSB +: DIGIT_W];
      default: w_digit = '0;
    endcase
  end

  seg7_decode u_decode (
    .i_digit (w_digit),
    .o_seg   (w_dec_seg)
  );

`ifdef SEG_LZB_EN
  // w_hi_zero[gi]: digit gi and every more significant digit are zero
  logic [NUM_DIGITS-1:0] w_hi_zero;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_hi_zero
    assign w_hi_zero[gi] = (w_src_bcd[SIGN_BIT-1:gi*DIGIT_W] == '0);
  end
  assign w_blank = (w_idx_next != 3'd0) && (w_idx_next < 3'(NUM_DIGITS)) &&
                   w_hi_zero[w_idx_next];
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_seg_next = w_dec_seg;
    if (w_src_v) begin
      w_seg_next = SEG_MINUS;
    end else if (w_idx_next == 3'(NUM_POS - 1)) begin
      w_seg_next = w_src_bcd[SIGN_BIT] ? SEG_MINUS : SEG_BLANK;
    end else if (w_blank) begin
      w_seg_next = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_snap   <= '0;
      r_snap_v <= 1'b0;
      r_an     <= NUM_POS'(1);
      r_seg    <= SEG_0;
      r_frame  <= 1'b0;
    end else begin
      r_cnt   <= w_tick ? '0 : r_cnt + CNT_W'(1);
      r_frame <= w_wrap;
      if (w_tick) begin
        r_idx <= w_idx_next;
        r_an  <= NUM_POS'(1) << w_idx_next;
        r_seg <= w_seg_next;
      end
      if (w_wrap) begin
        r_snap   <= bcd_in;
        r_snap_v <= v;
      end
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign frame = r_frame;

endmodule

// File: doc/bcd_seg_scanner.md
BCD_SEG_SCANNER -- requirements
Module: bcd_seg_scanner

Interface
REQ-001 Parameter: CLK_DIV, 50000, clk cycles per digit-scan tick (legal range >= 2).
REQ-002 Port: clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-low.
REQ-004 Port: bcd_in  input  21  signed BCD word: [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands, [19:16] ten-thousands, [20] sign (1 = negative).
REQ-005 Port: v  input  1  overflow flag from the binary-to-BCD stage.
REQ-006 Port: an  output  6  one-hot digit enable, active-high; bit 0 = rightmost position, bit 5 = sign position.
REQ-007 Port: seg  output  7  segment pattern {g,f,e,d,c,b,a}, active-high.
REQ-008 Port: frame  output  1  one-cycle pulse on the cycle a new snapshot is loaded.

Function
REQ-009 Prescaler SHALL count 0..CLK_DIV-1, wrap to 0, and assert the internal tick on the cycle where count == CLK_DIV-1.
REQ-010 Digit index idx SHALL advance by 1 on each tick and wrap 5 -> 0.
REQ-011 On the tick edge where idx wraps 5 -> 0, snapshot registers SHALL load bcd_in and v, and frame SHALL be 1 for exactly that following cycle; otherwise frame = 0.
REQ-012 bcd_in and v changes between wraps SHALL NOT affect the display (no tearing).
REQ-013 an and seg SHALL be registered and updated on the same edge as idx; an = 1 << idx; seg SHALL already reflect any snapshot loaded on that edge.
REQ-014 Digit decode SHALL be: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F; values A-F SHALL produce blank (00).
REQ-015 Positions 0-4 SHALL show the five BCD digits; position 5 SHALL show '-' (40) when the sign = 1, else blank (00).
REQ-016 When the snapshot v = 1, all six positions SHALL show '-' (40), regardless of bcd_in.
REQ-017 Between ticks, an and seg SHALL remain stable (no single-cycle glitches).

Reset
REQ-018 While rst = 0 at a rising edge, the block SHALL set: prescaler = 0, idx = 0, snapshot = 0, snapshot v = 0, an = 000001, seg = 3F, frame = 0.
REQ-019 Reset asserted mid-frame SHALL abandon the frame; the first tick after release SHALL move to idx 1 with snapshot = 0 until the next wrap.

Configuration
REQ-020 Macro SEG_LZB_EN defined: positions 4..1 SHALL be blank when that digit and every higher digit (up to position 4) are 0; position 0 is never blanked; the sign position is unaffected.
REQ-021 Macro SEG_LZB_EN undefined: all five digit positions SHALL always be decoded, including leading zeros.

Structure
REQ-022 Shared package seg_pkg SHALL hold the segment constants (digits 0-9, SEG_MINUS = 40, SEG_BLANK = 00), NUM_POS = 6, and the bcd_in field offsets.
REQ-023 A combinational sub-module seg7_decode (4-bit in, 7-bit out, blank for >9) SHALL be used for the digit decode; the prescaler, idx, snapshot, and blanking logic SHALL reside in bcd_seg_scanner.

Verification (CLK_DIV = 4)
REQ-024 Reset: hold rst = 0 for 3 cycles -> an = 000001, seg = 3F, frame = 0; after release, an moves to 000010 after 4 cycles.
REQ-025 bcd_in = 0x012345, v = 0 -> after the wrap, positions 0..5 show seg 6D, 66, 4F, 5B, 06, 00, each held for 4 cycles, with an one-hot in sequence.
REQ-026 bcd_in = {1, 0x00042} -> with SEG_LZB_EN: 5B, 66, 00, 00, 00, 40; without SEG_LZB_EN: 5B, 66, 3F, 3F, 3F, 40.
REQ-027 v = 1 with any bcd_in -> all six positions show 40 in the next frame; v returning to 0 mid-frame -> 40 persists until the following wrap.
REQ-028 Change bcd_in from 0x000011 to 0x000099 while idx = 2 -> the current frame still shows 06; frame pulses once at the wrap; the next frame shows 6F.
REQ-029 Assert rst = 0 for one cycle at idx = 3 -> the next cycle shows the reset values of REQ-018; scanning restarts from idx 0.
